muldiv_sequencer: RTL and testbench

- Multi-cycle sequencer for the ALU's MULT (alu_control 10) and DIV (alu_control 11) operations.
- Owns the HI/LO registers and runs a radix-2 iterative signed multiply or restoring divide over WIDTH iterations.
- Stalls the datapath through busy; single-cycle ALU ops never pass through it.
- Sits beside the ALU; the datapath reads hi/lo for MFHI/MFLO.

---
 rtl/muldiv_pkg.sv | 16 +
 rtl/muldiv_sequencer_if.sv | 26 ++
 rtl/muldiv_step.sv | 32 +++
 rtl/muldiv_sequencer.sv | 164 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the MULT/DIV sequencer.
// Optional build macro: MULDIV_EARLY_OUT_EN (see muldiv_sequencer.sv).
package muldiv_pkg;

    localparam logic [4:0] ALU_MULT = 5'd10;
    localparam logic [4:0] ALU_DIV  = 5'd11;

    localparam logic [63:0] DIV0_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } state_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the datapath and the MULT/DIV sequencer.
// The datapath is the master; the sequencer is the slave.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [4:0]       alu_control;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, alu_control, a, b, flush,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, alu_control, a, b, flush,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: add-shift for MULT, restoring subtract-shift for DIV.
// Operates on magnitudes; acc is the upper half, mq the multiplier/quotient.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             op_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mq,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH-1:0] acc_n,
    output logic [WIDTH-1:0] mq_n
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shl;
    logic [WIDTH:0] diff;
    logic           fits;

    always_comb begin
        sum  = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
        shl  = {acc, mq[WIDTH-1]};
        diff = shl - {1'b0, mcand};
        // carry out of the shift guarantees the divisor fits
        fits = shl[WIDTH] | ~diff[WIDTH];
        if (op_div) begin
            acc_n = fits ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
            mq_n  = {mq[WIDTH-2:0], fits};
        end else begin
            acc_n = sum[WIDTH:1];
            mq_n  = {sum[0], mq[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed MULT/DIV sequencer owning HI/LO.
// Define MULDIV_EARLY_OUT_EN to end MULT early once the multiplier runs out.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               rst_n,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    count;
    logic             op_div;
    logic             sign_q;
    logic             sign_r;
    logic             dz_pend;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dz;
    logic             done;

    logic             is_mult;
    logic             is_div;
    logic             accept;
    logic             b_zero;
    logic             last;
    logic             early;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] mq_n;
    logic [2*WIDTH-1:0] prod_nx;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] hi_fix;
    logic [WIDTH-1:0] lo_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op_div (op_div),
        .acc    (acc),
        .mq     (mq),
        .mcand  (mcand),
        .acc_n  (acc_n),
        .mq_n   (mq_n)
    );

    always_comb begin
        is_mult = (bus.alu_control == ALU_MULT);
        is_div  = (bus.alu_control == ALU_DIV);
        accept  = (state == IDLE) && bus.start && !bus.flush
                  && (is_mult || is_div);
        b_zero  = (bus.b == '0);
        a_mag   = bus.a[WIDTH-1] ? -bus.a : bus.a;
        b_mag   = bus.b[WIDTH-1] ? -bus.b : bus.b;
        last    = (count == CW'(WIDTH - 1));
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0]   ones;
    logic [WIDTH-1:0]   mask;
    logic [2*WIDTH-1:0] prod_sh;

    // low WIDTH-1-count bits of mq_n are still unconsumed multiplier
    always_comb begin
        ones    = '1;
        mask    = ones >> (int'(count) + 1);
        prod_sh = {acc_n, mq_n} >> (WIDTH - 1 - int'(count));
        early   = !op_div && ((mq_n & mask) == '0);
        prod_nx = early ? prod_sh : {acc_n, mq_n};
    end
`else
    always_comb begin
        early   = 1'b0;
        prod_nx = {acc_n, mq_n};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) state_n = (is_div && b_zero) ? FIX : ITER;
            end
            ITER: begin
                if (bus.flush)          state_n = IDLE;
                else if (last || early) state_n = FIX;
            end
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.busy        = (state != IDLE);
        bus.done        = done;
        bus.hi          = hi;
        bus.lo          = lo;
        bus.div_by_zero = dz;
    end

    // sign fix-up applied to the magnitude result
    always_comb begin
        prod   = {acc, mq};
        if (sign_q) prod = -prod;
        hi_fix = prod[2*WIDTH-1:WIDTH];
        lo_fix = prod[WIDTH-1:0];
        if (op_div) begin
            lo_fix = sign_q ? -mq : mq;
            hi_fix = sign_r ? -acc : acc;
            if (dz_pend) begin
                lo_fix = DIV0_QUOT[WIDTH-1:0];
                hi_fix = sign_r ? -mq : mq;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            op_div  <= 1'b0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            dz_pend <= 1'b0;
            acc     <= '0;
            mq      <= '0;
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            dz      <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= (state == FIX) && !bus.flush;
            if (accept) begin
                count   <= '0;
                op_div  <= is_div;
                sign_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                sign_r  <= bus.a[WIDTH-1];
                dz_pend <= is_div && b_zero;
                dz      <= 1'b0;
                acc     <= '0;
                mq      <= is_div ? a_mag : b_mag;
                mcand   <= is_div ? b_mag : a_mag;
            end else if (state == ITER && !bus.flush) begin
                {acc, mq} <= prod_nx;
                count     <= count + 1'b1;
            end else if (state == FIX && !bus.flush) begin
                hi <= hi_fix;
                lo <= lo_fix;
                dz <= dz_pend;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: golden model results queued at
// start, popped and compared when done pulses.
module tb_muldiv_sequencer;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    exp_t scb[$];
    logic [W-1:0] last_hi;
    logic [W-1:0] last_lo;
    logic         last_dz;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(logic [4:0] op, logic [W-1:0] a, logic [W-1:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.dz = 1'b0;
        if (op == 5'd10) begin
            p    = sa * sb;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == '0) begin
            e.hi = a;
            e.lo = '1;
            e.dz = 1'b1;
        end else begin
            p    = sa / sb;
            e.lo = p[31:0];
            p    = sa % sb;
            e.hi = p[31:0];
        end
        scb.push_back(e);
    endtask

    // exp_lat > 0: exact edge count after the start edge; 0: anywhere in 2..W+1
    task automatic run_op(string tag, logic [4:0] op, logic [W-1:0] a,
                          logic [W-1:0] b, int exp_lat, bit mid_start);
        int   lat;
        int   busy_cnt;
        bit   got;
        exp_t e;
        push_exp(op, a, b);
        bus.alu_control = op;
        bus.a = a;
        bus.b = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        busy_cnt = int'(bus.busy);
        lat = 0;
        got = 1'b0;
        while (lat < 100 && !got) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.done) got = 1'b1;
            else if (bus.busy) busy_cnt++;
            if (mid_start && lat == 5) begin
                bus.alu_control = 5'd11;
                bus.a = 32'd99;
                bus.b = 32'd0;
                bus.start = 1'b1;
            end
            if (lat == 6) bus.start = 1'b0;
        end
        bus.start = 1'b0;
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        if (got) begin
            e = scb.pop_front();
            check({tag, "_hi"}, 64'(bus.hi), 64'(e.hi));
            check({tag, "_lo"}, 64'(bus.lo), 64'(e.lo));
            check({tag, "_dz"}, 64'(bus.div_by_zero), 64'(e.dz));
            check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
            check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(lat));
            if (exp_lat > 0) check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
            else check({tag, "_latency_range"},
                       64'(lat >= 2 && lat <= W + 1), 64'd1);
            last_hi = e.hi;
            last_lo = e.lo;
            last_dz = e.dz;
        end
        @(posedge clk);
        #1 check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int   mlat;
        int   lat5;
        bit   seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_chk = 0;
        n_err = 0;
`ifdef MULDIV_EARLY_OUT_EN
        mlat = 0;
`else
        mlat = W + 1;
`endif
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.alu_control = 5'd0;
        bus.a = '0;
        bus.b = '0;
        bus.flush = 1'b0;
        #12;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_dz", 64'(bus.div_by_zero), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("mult_7_m3", 5'd10, 32'd7, -32'sd3, mlat, 1'b1);
        run_op("div_m17_5", 5'd11, -32'sd17, 32'd5, W + 1, 1'b0);
        run_op("div_123_0", 5'd11, 32'd123, 32'd0, 1, 1'b0);
        run_op("mult_2_2", 5'd10, 32'd2, 32'd2, mlat, 1'b0);
        run_op("mult_min_min", 5'd10, 32'h8000_0000, 32'h8000_0000, mlat, 1'b0);
        run_op("div_min_m1", 5'd11, 32'h8000_0000, 32'hFFFF_FFFF, W + 1, 1'b0);
        run_op("div_m7_0", 5'd11, -32'sd7, 32'd0, 1, 1'b0);
        run_op("div_100_m7", 5'd11, 32'd100, -32'sd7, W + 1, 1'b0);

        // early-out case: result must match; latency bounded
        lat5 = 0;
        push_exp(5'd10, 32'd5, 32'd1);
        bus.alu_control = 5'd10;
        bus.a = 32'd5;
        bus.b = 32'd1;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        seen = 1'b0;
        while (lat5 < 100 && !seen) begin
            @(posedge clk);
            lat5++;
            #1 if (bus.done) seen = 1'b1;
        end
        check("mult_5_1_done_seen", 64'(seen), 64'd1);
        if (seen) begin
            exp_t e;
            e = scb.pop_front();
            check("mult_5_1_hi", 64'(bus.hi), 64'(e.hi));
            check("mult_5_1_lo", 64'(bus.lo), 64'(e.lo));
            last_hi = e.hi;
            last_lo = e.lo;
            last_dz = e.dz;
`ifdef MULDIV_EARLY_OUT_EN
            check("mult_5_1_early", 64'(lat5 < W + 1), 64'd1);
`else
            check("mult_5_1_latency", 64'(lat5), 64'(W + 1));
`endif
        end
        @(posedge clk);
        #1;

        // unsupported opcode is ignored
        bus.alu_control = 5'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("bad_op_busy", 64'(bus.busy), 64'd0);

        // flush beats start in IDLE
        bus.alu_control = 5'd10;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_start_busy", 64'(bus.busy), 64'd0);

        // flush at iteration 10
        bus.alu_control = 5'd10;
        bus.a = 32'd1234;
        bus.b = 32'd77;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("flush_busy_before", 64'(bus.busy), 64'd1);
        repeat (10) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        check("flush_done", 64'(bus.done), 64'd0);
        check("flush_hi", 64'(bus.hi), 64'(last_hi));
        check("flush_lo", 64'(bus.lo), 64'(last_lo));
        check("flush_dz", 64'(bus.div_by_zero), 64'(last_dz));
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 if (bus.done) seen = 1'b1;
        end
        check("flush_no_done", 64'(seen), 64'd0);

        // async reset mid-DIV
        run_op("div_m1000_7", 5'd11, -32'sd1000, 32'd7, W + 1, 1'b0);
        bus.alu_control = 5'd11;
        bus.a = 32'd5000;
        bus.b = 32'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_hi", 64'(bus.hi), 64'd0);
        check("rst_mid_lo", 64'(bus.lo), 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("mult_after_rst", 5'd10, -32'sd12345, 32'd678, mlat, 1'b0);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
            if (i % 3 == 0) rb = -rb;
            run_op("rand", (i % 2 == 0) ? 5'd10 : 5'd11, ra, rb,
                   (i % 2 == 0) ? mlat : W + 1, 1'b0);
        end

        check("scb_empty", 64'(scb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
